// File: rtl/pr_bridge_multi.sv
// pr_bridge_multi: CPU-to-device bridge with address decode, wait states, bus timeout and error response.
// Define BRIDGE_ERR_LOG_EN to add ErrAddr/ErrCnt error logging.
module pr_bridge_multi #(
  parameter int                    NUM_DEV  = 4,
  parameter logic [NUM_DEV*32-1:0] DEV_BASE = {32'h7f30, 32'h7f20, 32'h7f10, 32'h7f00},
  parameter logic [31:0]           DEV_MASK = 32'hffff_fff0,
  parameter int                    TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PrReq,
  input  logic                  PrWe,
  input  logic [3:0]            PrBE,
  input  logic [31:0]           PrAddr,
  input  logic [31:0]           PrWD,
  output logic [31:0]           PrRD,
  output logic                  PrReady,
  output logic                  PrErr,
  output logic [29:0]           DEV_Addr,
  output logic [31:0]           DEV_WD,
  output logic [3:0]            DEV_BE,
  output logic [NUM_DEV-1:0]    DEV_WE,
  output logic [NUM_DEV-1:0]    DEV_RE,
  input  logic [NUM_DEV-1:0]    DEV_Ready,
  input  logic [NUM_DEV*32-1:0] DEV_RD
`ifdef BRIDGE_ERR_LOG_EN
  ,
  output logic [31:0]           ErrAddr,
  output logic [7:0]            ErrCnt
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d, rdata_q, rdata_d, sel_rd;
  logic [3:0] be_q, be_d;
  logic we_q, we_d, err_q, err_d, sel_rdy;
  logic [NUM_DEV-1:0] sel_q, sel_d, hit;
  logic [7:0] cnt_q, cnt_d;
  // descending scan so the lowest matching index is the one left standing
  always_comb begin
    hit = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--)
      if ((PrAddr & DEV_MASK) == (DEV_BASE[32*i +: 32] & DEV_MASK)) begin
        hit = '0;
        hit[i] = 1'b1;
      end
  end
  always_comb begin
    sel_rd = '0;
    for (int i = 0; i < NUM_DEV; i++) sel_rd |= sel_q[i] ? DEV_RD[32*i +: 32] : 32'h0;
  end
  assign sel_rdy = |(DEV_Ready & sel_q);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    we_d    = we_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (PrReq) begin
        addr_d  = PrAddr[31:2];
        wd_d    = PrWD & {{8{PrBE[3]}}, {8{PrBE[2]}}, {8{PrBE[1]}}, {8{PrBE[0]}}};
        be_d    = PrBE;
        we_d    = PrWe;
        sel_d   = hit;
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = ~|hit;
        state_d = |hit ? ACCESS : RESP;
      end
      ACCESS: if (sel_rdy) begin
        rdata_d = we_q ? 32'h0 : sel_rd;
        err_d   = 1'b0;
        state_d = RESP;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  assign PrReady  = state_q == RESP;
  assign PrRD     = PrReady ? rdata_q : 32'h0;
  assign PrErr    = PrReady & err_q;
  assign DEV_Addr = addr_q;
  assign DEV_WD   = wd_q;
  assign DEV_BE   = be_q;
  assign DEV_WE   = (state_q == ACCESS && we_q) ? sel_q : '0;
  assign DEV_RE   = (state_q == ACCESS && !we_q) ? sel_q : '0;
`ifdef BRIDGE_ERR_LOG_EN
  logic [1:0] lo_q;
  logic err_evt;
  assign err_evt = state_q != RESP && state_d == RESP && err_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      lo_q    <= '0;
      ErrAddr <= '0;
      ErrCnt  <= '0;
    end else begin
      if (state_q == IDLE && PrReq) lo_q <= PrAddr[1:0];
      if (err_evt) begin
        ErrAddr <= state_q == IDLE ? PrAddr : {addr_q, lo_q};
        ErrCnt  <= ErrCnt == 8'hff ? ErrCnt : ErrCnt + 8'd1;
      end
    end
`endif
endmodule

// File: tb/tb_pr_bridge_multi.sv
// tb_pr_bridge_multi: directed vector table, hand sequences and randomized accesses checked against a spec-level model.
module tb_pr_bridge_multi;
  localparam int TO = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic PrReq = 1'b0, PrWe = 1'b0;
  logic [3:0] PrBE = '0;
  logic [31:0] PrAddr = '0, PrWD = '0, PrRD;
  logic PrReady, PrErr;
  logic [29:0] DEV_Addr;
  logic [31:0] DEV_WD;
  logic [3:0] DEV_BE, DEV_WE, DEV_RE;
  logic [3:0] DEV_Ready = '0;
  logic [127:0] DEV_RD = '0;
`ifdef BRIDGE_ERR_LOG_EN
  logic [31:0] ErrAddr, exp_ea = '0;
  logic [7:0] ErrCnt, exp_ec = '0;
`endif
  int total = 0, bad = 0;

  pr_bridge_multi dut (
    .clk(clk), .reset(reset), .PrReq(PrReq), .PrWe(PrWe), .PrBE(PrBE), .PrAddr(PrAddr), .PrWD(PrWD),
    .PrRD(PrRD), .PrReady(PrReady), .PrErr(PrErr), .DEV_Addr(DEV_Addr), .DEV_WD(DEV_WD), .DEV_BE(DEV_BE),
    .DEV_WE(DEV_WE), .DEV_RE(DEV_RE), .DEV_Ready(DEV_Ready), .DEV_RD(DEV_RD)
`ifdef BRIDGE_ERR_LOG_EN
    , .ErrAddr(ErrAddr), .ErrCnt(ErrCnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wd; int dly; logic [31:0] rdv;
    int lat; logic [3:0] wev; logic [3:0] rev; int scnt; logic [31:0] prd; logic perr; logic [31:0] dwd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Device windows are 16-byte ranges starting at 0x7f00 + 16*i; first match wins.
  function automatic vec_t model(input vec_t s);
    vec_t r = s;
    int sel = -1;
    for (int i = 0; i < 4; i++)
      if (sel < 0 && s.addr >= 32'h7f00 + 32'(16 * i) && s.addr < 32'h7f10 + 32'(16 * i)) sel = i;
    r.wev = '0;
    r.rev = '0;
    r.dwd = '0;
    for (int b = 0; b < 4; b++) if (s.be[b]) r.dwd[8*b +: 8] = s.wd[8*b +: 8];
    if (sel < 0) begin
      r.lat = 1; r.scnt = 0; r.prd = '0; r.perr = 1'b1;
    end else begin
      if (s.we) r.wev[sel] = 1'b1; else r.rev[sel] = 1'b1;
      if (s.dly >= 1 && s.dly <= TO) begin
        r.lat = s.dly + 1; r.scnt = s.dly; r.perr = 1'b0; r.prd = s.we ? 32'h0 : s.rdv;
      end else begin
        r.lat = TO + 1; r.scnt = TO; r.perr = 1'b1; r.prd = '0;
      end
    end
    return r;
  endfunction

  task automatic run(input vec_t v, input string tag);
    logic [3:0] selm, wes, res, dbe;
    logic [31:0] prd, dwd;
    logic [29:0] dad;
    logic perr;
    int lat, sc;
    selm = v.wev | v.rev;
    @(negedge clk);
    PrReq = 1'b1; PrWe = v.we; PrBE = v.be; PrAddr = v.addr; PrWD = v.wd;
    for (int i = 0; i < 4; i++) DEV_RD[32*i +: 32] = selm[i] ? v.rdv : ~v.rdv;
    DEV_Ready = 4'($urandom) & ~selm;
    @(posedge clk);
    lat = 0; sc = 0; wes = '0; res = '0; prd = '0; perr = 1'b0; dwd = '0; dbe = '0; dad = '0;
    for (int n = 1; n <= TO + 8; n++) begin
      @(negedge clk);
      if (PrReady) begin
        lat = n; prd = PrRD; perr = PrErr; dwd = DEV_WD; dbe = DEV_BE; dad = DEV_Addr;
        chk({tag, " resp_strobes"}, {28'h0, DEV_WE | DEV_RE}, 32'h0);
        break;
      end
      chk({tag, " rd_idle"}, PrRD, 32'h0);
      chk({tag, " err_idle"}, {31'h0, PrErr}, 32'h0);
      if (|(DEV_WE | DEV_RE)) sc++;
      wes |= DEV_WE;
      res |= DEV_RE;
      DEV_Ready = (4'($urandom) & ~selm) | (v.dly == n ? selm : 4'h0);
    end
    PrReq = 1'b0;
    DEV_Ready = '0;
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " we_strobe"}, {28'h0, wes}, {28'h0, v.wev});
    chk({tag, " re_strobe"}, {28'h0, res}, {28'h0, v.rev});
    chk({tag, " strobe_cycles"}, sc, v.scnt);
    chk({tag, " PrRD"}, prd, v.prd);
    chk({tag, " PrErr"}, {31'h0, perr}, {31'h0, v.perr});
    chk({tag, " DEV_WD"}, dwd, v.dwd);
    chk({tag, " DEV_BE"}, {28'h0, dbe}, {28'h0, v.be});
    chk({tag, " DEV_Addr"}, {2'b0, dad}, {2'b0, v.addr[31:2]});
`ifdef BRIDGE_ERR_LOG_EN
    if (v.perr) begin
      exp_ea = v.addr;
      exp_ec = exp_ec == 8'hff ? exp_ec : exp_ec + 8'd1;
    end
    @(negedge clk);
    chk({tag, " ErrAddr"}, ErrAddr, exp_ea);
    chk({tag, " ErrCnt"}, {24'h0, ErrCnt}, {24'h0, exp_ec});
`endif
  endtask

  vec_t tbl[8];
  vec_t s, v;

  initial begin
    tbl[0] = '{32'h7f14, 1'b0, 4'hf, 32'h0, 1, 32'hdeadbeef, 2, 4'h0, 4'h2, 1, 32'hdeadbeef, 1'b0, 32'h0};
    tbl[1] = '{32'h7f08, 1'b1, 4'b0101, 32'h11223344, 1, 32'h55aa55aa, 2, 4'h1, 4'h0, 1, 32'h0, 1'b0, 32'h00220044};
    tbl[2] = '{32'h7f24, 1'b0, 4'hf, 32'hffffffff, 5, 32'hcafe0002, 6, 4'h0, 4'h4, 5, 32'hcafe0002, 1'b0, 32'hffffffff};
    tbl[3] = '{32'h7f34, 1'b0, 4'hf, 32'h0, 0, 32'h12345678, 17, 4'h0, 4'h8, 16, 32'h0, 1'b1, 32'h0};
    tbl[4] = '{32'h1000, 1'b1, 4'hf, 32'ha5a5a5a5, 1, 32'h0, 1, 4'h0, 4'h0, 0, 32'h0, 1'b1, 32'ha5a5a5a5};
    tbl[5] = '{32'h7f3c, 1'b0, 4'b1000, 32'h89abcdef, 16, 32'h0badf00d, 17, 4'h0, 4'h8, 16, 32'h0badf00d, 1'b0, 32'h89000000};
    tbl[6] = '{32'h7f40, 1'b0, 4'hf, 32'h0, 1, 32'h0, 1, 4'h0, 4'h0, 0, 32'h0, 1'b1, 32'h0};
    tbl[7] = '{32'h7f1c, 1'b1, 4'b0010, 32'hdeadbeef, 3, 32'h77, 4, 4'h2, 4'h0, 3, 32'h0, 1'b0, 32'h0000be00};
    repeat (2) @(negedge clk);
    chk("rst PrReady", {31'h0, PrReady}, 32'h0);
    chk("rst PrRD", PrRD, 32'h0);
    chk("rst PrErr", {31'h0, PrErr}, 32'h0);
    chk("rst strobes", {24'h0, DEV_WE, DEV_RE}, 32'h0);
    chk("rst DEV_Addr", {2'b0, DEV_Addr}, 32'h0);
    chk("rst DEV_WD", DEV_WD, 32'h0);
    chk("rst DEV_BE", {28'h0, DEV_BE}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("tbl%0d", i));
    // request held through PrReady is re-accepted after exactly one idle cycle
    @(negedge clk);
    PrReq = 1'b1; PrWe = 1'b0; PrAddr = 32'h1000;
    @(posedge clk);
    @(negedge clk);
    chk("b2b first", {31'h0, PrReady}, 32'h1);
    @(negedge clk);
    chk("b2b idle", {31'h0, PrReady}, 32'h0);
    @(negedge clk);
    chk("b2b second", {31'h0, PrReady}, 32'h1);
    PrReq = 1'b0;
    @(negedge clk);
    chk("b2b after", {31'h0, PrReady}, 32'h0);
`ifdef BRIDGE_ERR_LOG_EN
    exp_ea = 32'h1000;
    exp_ec = exp_ec + 8'd2;
    chk("b2b ErrCnt", {24'h0, ErrCnt}, {24'h0, exp_ec});
`endif
    // asynchronous reset in the middle of a stalled read
    @(negedge clk);
    PrReq = 1'b1; PrWe = 1'b0; PrBE = 4'hf; PrAddr = 32'h7f24; DEV_Ready = '0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("abort pre RE", {28'h0, DEV_RE}, 32'h4);
    #2 reset = 1'b0;
    #1;
    chk("abort RE", {28'h0, DEV_RE}, 32'h0);
    chk("abort WE", {28'h0, DEV_WE}, 32'h0);
    chk("abort PrReady", {31'h0, PrReady}, 32'h0);
    chk("abort DEV_Addr", {2'b0, DEV_Addr}, 32'h0);
    PrReq = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort no ready", {31'h0, PrReady}, 32'h0);
    end
`ifdef BRIDGE_ERR_LOG_EN
    exp_ea = '0;
    exp_ec = '0;
    chk("abort ErrCnt", {24'h0, ErrCnt}, 32'h0);
`endif
    reset = 1'b1;
    s = '{32'h7f04, 1'b0, 4'hf, 32'h0, 1, 32'h600dd00d, 0, 4'h0, 4'h0, 0, 32'h0, 1'b0, 32'h0};
    run(model(s), "post_reset");
    for (int k = 0; k < 40; k++) begin
      s.addr = $urandom_range(0, 3) == 0 ? $urandom
             : 32'h7f00 + 32'($urandom_range(0, 4)) * 32'd16 + 32'($urandom_range(0, 15));
      s.we = 1'($urandom);
      s.be = 4'($urandom);
      s.wd = $urandom;
      s.rdv = $urandom;
      s.dly = $urandom_range(0, TO + 2);
      v = model(s);
      run(v, $sformatf("rnd%0d", k));
    end
`ifdef BRIDGE_ERR_LOG_EN
    @(negedge clk);
    PrReq = 1'b1; PrAddr = 32'h2000;
    repeat (560) @(negedge clk);
    PrReq = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat ErrCnt", {24'h0, ErrCnt}, 32'hff);
    chk("sat ErrAddr", ErrAddr, 32'h2000);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
